// File: rtl/branch_hazard_pkg.sv
// Shared types for the ID-stage branch hazard unit.
//   slot_t     : destination info tracked per shadow pipeline slot (EX, MEM)
//   ZERO_REG   : architectural zero register, never a hazard source
//   NOP_SLOT   : empty slot loaded on reset or when a bubble is inserted
//   slot_match : slot s will write register r (register 0 excluded)
package branch_hazard_pkg;

  localparam int SLOT_RD_W = 5;

  localparam logic [SLOT_RD_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic                 memread;
    logic [SLOT_RD_W-1:0] rd;
  } slot_t;

  localparam slot_t NOP_SLOT = '0;

  function automatic logic slot_match(slot_t s, logic [SLOT_RD_W-1:0] r);
    return s.valid & s.regwrite & (s.rd != ZERO_REG) & (s.rd == r);
  endfunction

endpackage

// File: rtl/hazard_slot_reg.sv
// One stage of the shadow pipeline holding destination info.
//   clk, reset_n : core clock, async active-low reset (slot cleared)
//   bubble       : load NOP_SLOT instead of d on this edge
//   d            : next slot contents
//   q            : registered slot
module hazard_slot_reg
  import branch_hazard_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  bubble,
  input  slot_t d,
  output slot_t q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    q <= NOP_SLOT;
    else if (bubble) q <= NOP_SLOT;
    else             q <= d;
  end

endmodule

// File: rtl/branch_hazard_unit.sv
// ID-stage branch hazard unit: stall, bubble, flush and comparator forward
// controls, derived from a private two-slot (EX, MEM) shadow pipeline.
//   clk, reset_n          : core clock, async active-low reset
//   Rs_ID/Rt_ID           : source registers of the ID instruction
//   Uses_Rs_ID/Uses_Rt_ID : ID instruction reads Rs / Rt
//   Branch_ID             : ID instruction is a beq (reads both sources)
//   RegWrite_ID/MemRead_ID/Write_Reg_ID : ID instruction destination info
//   Comparetor_ID         : equality result of the ID comparator
//   Stall_ID/Bubble_ID_EX : hold PC+IF_ID, inject NOP into ID_EX
//   Flush_IF_ID           : taken branch, zero IF_ID
//   Forward_C_ID/D_ID     : comparator operand 1/2 from ALU_Result_MEM
//   Stall_Count           : saturating count of stall cycles since reset
module branch_hazard_unit
  import branch_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = SLOT_RD_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] Rs_ID,
  input  logic [REG_ADDR_W-1:0] Rt_ID,
  input  logic                  Uses_Rs_ID,
  input  logic                  Uses_Rt_ID,
  input  logic                  Branch_ID,
  input  logic                  RegWrite_ID,
  input  logic                  MemRead_ID,
  input  logic [REG_ADDR_W-1:0] Write_Reg_ID,
  input  logic                  Comparetor_ID,
  output logic                  Stall_ID,
  output logic                  Bubble_ID_EX,
  output logic                  Flush_IF_ID,
  output logic                  Forward_C_ID,
  output logic                  Forward_D_ID,
  output logic [CNT_W-1:0]      Stall_Count
);

  slot_t ex_d, ex_q, mem_q;
  logic  use_rs, use_rt, stall_rs, stall_rt, stall;

  assign ex_d = '{valid: 1'b1, regwrite: RegWrite_ID, memread: MemRead_ID, rd: Write_Reg_ID};

  hazard_slot_reg u_ex (
    .clk    (clk),
    .reset_n(reset_n),
    .bubble (stall),
    .d      (ex_d),
    .q      (ex_q)
  );

  hazard_slot_reg u_mem (
    .clk    (clk),
    .reset_n(reset_n),
    .bubble (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  // A branch compares both operands in ID, so it reads both regardless of
  // the Uses_* decode bits.
  assign use_rs = Branch_ID | Uses_Rs_ID;
  assign use_rt = Branch_ID | Uses_Rt_ID;

  // Branch: anything in EX is too late to forward, and a load in MEM only
  // becomes visible through the write-first register file one cycle later.
  // Non-branch: only a load in EX needs to wait (classic load-use).
  function automatic logic src_stall(logic [REG_ADDR_W-1:0] r, logic use_r);
    logic ex_hit, mem_hit;
    ex_hit  = slot_match(ex_q, r);
    mem_hit = slot_match(mem_q, r);
    if (!use_r)         return 1'b0;
    else if (Branch_ID) return ex_hit | (mem_hit & mem_q.memread);
    else                return ex_hit & ex_q.memread;
  endfunction

  assign stall_rs = src_stall(Rs_ID, use_rs);
  assign stall_rt = src_stall(Rt_ID, use_rt);

  // Outputs are forced low while reset is held, even though the ID inputs
  // may be asserting a taken branch.
  assign stall        = reset_n & (stall_rs | stall_rt);
  assign Stall_ID     = stall;
  assign Bubble_ID_EX = stall;
  assign Flush_IF_ID  = reset_n & Branch_ID & Comparetor_ID & ~stall;
  assign Forward_C_ID = reset_n & Branch_ID & slot_match(mem_q, Rs_ID) & ~mem_q.memread;
  assign Forward_D_ID = reset_n & Branch_ID & slot_match(mem_q, Rt_ID) & ~mem_q.memread;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      Stall_Count <= '0;
    else if (stall && ~&Stall_Count)   Stall_Count <= Stall_Count + 1'b1;
  end

endmodule

// File: tb/tb_branch_hazard_unit.sv
module tb_branch_hazard_unit;

  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] Rs_ID, Rt_ID, Write_Reg_ID;
  logic Uses_Rs_ID, Uses_Rt_ID, Branch_ID, RegWrite_ID, MemRead_ID, Comparetor_ID;
  logic Stall_ID, Bubble_ID_EX, Flush_IF_ID, Forward_C_ID, Forward_D_ID;
  logic [CNT_W-1:0] Stall_Count;

  branch_hazard_unit #(.REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Uses_Rs_ID(Uses_Rs_ID), .Uses_Rt_ID(Uses_Rt_ID),
    .Branch_ID(Branch_ID), .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID),
    .Write_Reg_ID(Write_Reg_ID), .Comparetor_ID(Comparetor_ID),
    .Stall_ID(Stall_ID), .Bubble_ID_EX(Bubble_ID_EX), .Flush_IF_ID(Flush_IF_ID),
    .Forward_C_ID(Forward_C_ID), .Forward_D_ID(Forward_D_ID), .Stall_Count(Stall_Count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: issued instructions by age (index 0 = one cycle ago,
  // index 1 = two cycles ago). A producer is usable by the consumer once it
  // is old enough: branch needs ALU age>=2 (forwarded from MEM), load age>=3;
  // non-branch needs load age>=2, ALU always ready.
  typedef struct { bit v; bit rw; bit mr; bit [4:0] rd; } ent_t;
  ent_t hist [2];
  int   m_cnt;
  bit   m_stall, m_flush, m_fc, m_fd;

  function automatic bit writes(ent_t e, bit [4:0] r);
    return e.v && e.rw && e.rd != 0 && e.rd == r;
  endfunction

  function automatic bit src_blocked(bit [4:0] r, bit used);
    int need;
    if (!used) return 0;
    for (int age = 1; age <= 2; age++) begin
      if (writes(hist[age-1], r)) begin
        need = Branch_ID ? (hist[age-1].mr ? 3 : 2) : (hist[age-1].mr ? 2 : 1);
        // nearest producer is the one the pipeline would deliver
        return age < need;
      end
    end
    return 0;
  endfunction

  task automatic model_eval();
    bit s;
    s = src_blocked(Rs_ID, Branch_ID | Uses_Rs_ID) | src_blocked(Rt_ID, Branch_ID | Uses_Rt_ID);
    m_stall = reset_n && s;
    m_flush = reset_n && Branch_ID && Comparetor_ID && !s;
    m_fc = reset_n && Branch_ID && writes(hist[1], Rs_ID) && !hist[1].mr;
    m_fd = reset_n && Branch_ID && writes(hist[1], Rt_ID) && !hist[1].mr;
  endtask

  task automatic model_clear();
    hist[0] = '{0, 0, 0, 0};
    hist[1] = '{0, 0, 0, 0};
    m_cnt = 0;
  endtask

  task automatic model_clock();
    if (!reset_n) begin
      model_clear();
      return;
    end
    if (m_stall && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    hist[1] = hist[0];
    if (m_stall) hist[0] = '{0, 0, 0, 0};
    else         hist[0] = '{1, RegWrite_ID, MemRead_ID, Write_Reg_ID};
  endtask

  task automatic set_in(input bit br, input bit [4:0] rs, input bit [4:0] rt,
                        input bit urs, input bit urt, input bit rw, input bit mr,
                        input bit [4:0] wr, input bit cmp);
    Branch_ID = br; Rs_ID = rs; Rt_ID = rt; Uses_Rs_ID = urs; Uses_Rt_ID = urt;
    RegWrite_ID = rw; MemRead_ID = mr; Write_Reg_ID = wr; Comparetor_ID = cmp;
  endtask

  task automatic nop();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called at negedge with inputs applied: compare DUT to the model.
  task automatic eval();
    #1;
    model_eval();
    chk("stall",  Stall_ID,     m_stall);
    chk("bubble", Bubble_ID_EX, m_stall);
    chk("flush",  Flush_IF_ID,  m_flush);
    chk("fwd_c",  Forward_C_ID, m_fc);
    chk("fwd_d",  Forward_D_ID, m_fd);
    chk("count",  Stall_Count,  m_cnt);
  endtask

  task automatic adv();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic step();
    eval();
    adv();
  endtask

  task automatic rst_pulse();
    reset_n = 1'b0;
    model_clear();
    eval();
    adv();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    model_clear();
    set_in(1, 3, 3, 1, 1, 1, 0, 3, 1);
    @(negedge clk);
    adv();
    #1;
    chk("rst_stall", Stall_ID, 0);
    chk("rst_bubble", Bubble_ID_EX, 0);
    chk("rst_flush", Flush_IF_ID, 0);
    chk("rst_fc", Forward_C_ID, 0);
    chk("rst_fd", Forward_D_ID, 0);
    chk("rst_cnt", Stall_Count, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // ALU -> branch: one stall then forward from MEM on Rs
    nop(); step();
    set_in(0, 1, 2, 1, 1, 1, 0, 3, 0); step();          // add $3
    set_in(1, 3, 4, 1, 1, 0, 0, 0, 0); eval();           // beq $3,$4
    chk("t2_stall", Stall_ID, 1); chk("t2_bubble", Bubble_ID_EX, 1); adv();
    eval();
    chk("t2_stall_clr", Stall_ID, 0); chk("t2_fc", Forward_C_ID, 1);
    chk("t2_fd", Forward_D_ID, 0); chk("t2_cnt", Stall_Count, 1); adv();

    // load -> branch: two stalls
    rst_pulse();
    set_in(0, 1, 0, 1, 0, 1, 1, 5, 0); step();          // lw $5
    set_in(1, 6, 5, 1, 1, 0, 0, 0, 0); eval();
    chk("t3_s1", Stall_ID, 1); adv();
    eval(); chk("t3_s2", Stall_ID, 1); adv();
    eval(); chk("t3_s3", Stall_ID, 0); chk("t3_fd", Forward_D_ID, 0);
    chk("t3_cnt", Stall_Count, 2); adv();

    // load -> ALU use, with and without the source read
    rst_pulse();
    set_in(0, 1, 0, 1, 0, 1, 1, 2, 0); step();          // lw $2
    set_in(0, 2, 7, 1, 0, 1, 0, 8, 0); eval();
    chk("t4_use", Stall_ID, 1); adv();
    eval(); chk("t4_use_clr", Stall_ID, 0); adv();
    rst_pulse();
    set_in(0, 1, 0, 1, 0, 1, 1, 2, 0); step();
    set_in(0, 2, 2, 0, 0, 1, 0, 8, 0); eval();
    chk("t4_nouse", Stall_ID, 0); adv();
    set_in(0, 1, 0, 1, 0, 1, 1, 0, 0); step();          // lw $0
    set_in(0, 1, 0, 1, 0, 1, 0, 0, 0); step();          // add $0
    set_in(1, 0, 0, 1, 1, 0, 0, 0, 1); eval();
    chk("t4_r0_stall", Stall_ID, 0); chk("t4_r0_fc", Forward_C_ID, 0); adv();

    // taken branch flush, and flush held off by a stall
    rst_pulse();
    nop(); step();
    set_in(1, 1, 2, 1, 1, 0, 0, 0, 1); eval();
    chk("t5_flush", Flush_IF_ID, 1); adv();
    nop(); eval(); chk("t5_flush_off", Flush_IF_ID, 0); adv();
    set_in(0, 1, 2, 1, 1, 1, 0, 3, 0); step();
    set_in(1, 3, 4, 1, 1, 0, 0, 0, 1); eval();
    chk("t5_stall_noflush", Flush_IF_ID, 0); adv();
    eval(); chk("t5_flush_late", Flush_IF_ID, 1); adv();

    // reset between producer and branch clears the slots
    set_in(0, 1, 0, 1, 0, 1, 1, 7, 0); step();          // lw $7
    rst_pulse();
    set_in(1, 7, 7, 1, 1, 0, 0, 0, 0); eval();
    chk("t6_nostall", Stall_ID, 0); adv();

    // counter saturation: lw then a held beq gives 2 stalls each round
    for (int k = 0; k < 20; k++) begin
      set_in(0, 1, 0, 1, 0, 1, 1, 9, 0); step();
      set_in(1, 9, 9, 1, 1, 0, 0, 0, 0); step(); step(); step();
    end
    nop(); eval();
    chk("sat_cnt", Stall_Count, (1 << CNT_W) - 1); adv();

    // randomized traffic on a small register range to provoke hazards
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst_pulse();
      end else begin
        set_in($urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
               5'($urandom_range(0, 3)), 1'($urandom));
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
